// File: rtl/ddr3_arbiter_if.sv
// Bundle of the two requester ports, the calibration flag and the MIG-style app_* bus
// that ddr3_arbiter shares. The slave modport is the arbiter's view; the master modport is the environment's view.
interface ddr3_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
) ();
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ack;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ack;

  logic              init_calib_complete;

  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_ack,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_ack,
    input  init_calib_complete,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_ack,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_ack,
    output init_calib_complete,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr3_arbiter.sv
// Round-robin arbiter sharing one ddr3_ctrl app_* interface between two line-sized requesters.
// One transaction in flight: IDLE -> CMD -> (RDWAIT) -> DONE -> IDLE, with a one-cycle ack in DONE.
module ddr3_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
) (
  input  logic          clk,
  input  logic          rst,
  ddr3_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMD    = 2'd1,
    S_RDWAIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_last;
  logic              r_gnt;
  logic              r_rd;
  logic              r_cmd_pend;
  logic              r_data_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_start;
  logic              w_gnt;
  logic              w_cmd_done;
  logic              w_data_done;
  logic              w_app_en;
  logic              w_wdf_wren;

  // Both ports requesting: the port not granted last time wins; otherwise the lone requester.
  assign w_gnt       = bus.p1_req & (~bus.p0_req | ~r_last);
  assign w_start     = (r_state == S_IDLE) & bus.init_calib_complete & (bus.p0_req | bus.p1_req);

  assign w_app_en    = (r_state == S_CMD) & r_cmd_pend;
  assign w_wdf_wren  = (r_state == S_CMD) & r_data_pend;
  assign w_cmd_done  = w_app_en & bus.app_rdy;
  assign w_data_done = w_wdf_wren & bus.app_wdf_rdy;

  assign bus.app_en       = w_app_en;
  assign bus.app_wdf_wren = w_wdf_wren;
  assign bus.app_wdf_end  = w_wdf_wren;
  assign bus.app_wdf_mask = '0;
  assign bus.app_addr     = r_addr;
  assign bus.app_cmd      = {2'b00, r_rd};
  assign bus.app_wdf_data = r_wdata;
  assign bus.p0_ack       = (r_state == S_DONE) & ~r_gnt;
  assign bus.p1_ack       = (r_state == S_DONE) &  r_gnt;
  assign bus.p0_rdata     = r_rdata0;
  assign bus.p1_rdata     = r_rdata1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (r_rd) begin
          if (w_cmd_done) w_state_nxt = S_RDWAIT;
        end else begin
          // Command and write-data handshakes may finish in either order or together.
          if ((w_cmd_done | ~r_cmd_pend) & (w_data_done | ~r_data_pend)) w_state_nxt = S_DONE;
        end
      end
      S_RDWAIT: begin
        if (bus.app_rd_data_valid) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_gnt       <= 1'b0;
      r_rd        <= 1'b0;
      r_cmd_pend  <= 1'b0;
      r_data_pend <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start) begin
        r_gnt       <= w_gnt;
        r_last      <= w_gnt;
        r_addr      <= w_gnt ? bus.p1_addr  : bus.p0_addr;
        r_wdata     <= w_gnt ? bus.p1_wdata : bus.p0_wdata;
        r_rd        <= w_gnt ? ~bus.p1_we   : ~bus.p0_we;
        r_cmd_pend  <= 1'b1;
        r_data_pend <= w_gnt ? bus.p1_we    : bus.p0_we;
      end else begin
        if (w_cmd_done)  r_cmd_pend  <= 1'b0;
        if (w_data_done) r_data_pend <= 1'b0;
      end

      // Read data outside RDWAIT is stray and never reaches a port.
      if ((r_state == S_RDWAIT) && bus.app_rd_data_valid) begin
        if (r_gnt) r_rdata1 <= bus.app_rd_data;
        else       r_rdata0 <= bus.app_rd_data;
      end
    end
  end

endmodule
